branch_step_ctrl: RTL and testbench



---
 rtl/branch_step_ctrl.sv | 104 ++++++++++
 tb/tb_branch_step_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/branch_step_ctrl.sv
// branch_step_ctrl: hardwired T0..T6 fetch + conditional-branch step sequencer (optional MEM_WAIT_EN: T1 waits for mem_ready)
module branch_step_ctrl #(
  parameter int DATA_W = 32,
  parameter logic [4:0] OPC_BR = 5'b10010,
  parameter int OPC_MSB = 31,
  parameter int C2_LSB = 19
) (
  input  logic              Clock,
  input  logic              Clear,
  input  logic              start,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] bus,
  input  logic [DATA_W-1:0] ir,
  output logic              PCout,
  output logic              MARin,
  output logic              IncPC,
  output logic              Zin,
  output logic              Read,
  output logic              MDRin,
  output logic              PCin,
  output logic              MDRout,
  output logic              IRin,
  output logic              Gra,
  output logic              Rout,
  output logic              CONin,
  output logic              Yin,
  output logic              Cout,
  output logic              ZLOout,
  output logic              con,
  output logic              busy,
  output logic              done,
  output logic              illegal
);
  typedef enum logic [2:0] {IDLE, T0, T1, T2, T3, T4, T5, T6} state_t;
  state_t state, state_n;
  logic illegal_q;
  logic first_t1;
  logic opc_ok;
  logic cond;
  logic [1:0] c2;
  logic unused_bits;
  assign opc_ok = ir[OPC_MSB -: 5] == OPC_BR;
  assign c2 = ir[C2_LSB+1:C2_LSB];
  assign cond = c2[1] ? (bus[DATA_W-1] == c2[0]) : ((bus == '0) ^ c2[0]);
  assign unused_bits = ^{ir, mem_ready};
  // state register, CON flip-flop, illegal pulse and first-T1 marker
  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      state     <= IDLE;
      con       <= 1'b0;
      illegal_q <= 1'b0;
      first_t1  <= 1'b1;
    end else begin
      state     <= state_n;
      con       <= (state == T3) ? cond : con;
      illegal_q <= (state == T2) && !opc_ok;
      first_t1  <= state != T1;
    end
  end
  // next-step sequencing
  always_comb begin
    state_n = IDLE;
    case (state)
      IDLE: state_n = start ? T0 : IDLE;
      T0:   state_n = T1;
`ifdef MEM_WAIT_EN
      T1:   state_n = mem_ready ? T2 : T1;
`else
      T1:   state_n = T2;
`endif
      T2:   state_n = opc_ok ? T3 : IDLE;
      T3:   state_n = T4;
      T4:   state_n = T5;
      T5:   state_n = T6;
      T6:   state_n = start ? T0 : IDLE;
      default: state_n = IDLE;
    endcase
  end
  // Moore strobe decode; PCin in T1 only on its first cycle so PC increments once
  always_comb begin
    PCout   = (state == T0) || (state == T4);
    MARin   = state == T0;
    IncPC   = state == T0;
    Zin     = (state == T0) || (state == T5);
    Read    = state == T1;
    MDRin   = state == T1;
`ifdef MEM_WAIT_EN
    PCin    = ((state == T1) && first_t1) || ((state == T6) && con);
`else
    PCin    = (state == T1) || ((state == T6) && con);
`endif
    MDRout  = state == T2;
    IRin    = state == T2;
    Gra     = state == T3;
    Rout    = state == T3;
    CONin   = state == T3;
    Yin     = state == T4;
    Cout    = state == T5;
    ZLOout  = state == T6;
    busy    = state != IDLE;
    done    = state == T6;
    illegal = illegal_q;
  end
endmodule

// File: tb/tb_branch_step_ctrl.sv
// tb_branch_step_ctrl: directed bench with a step-table model checked every cycle
module tb_branch_step_ctrl;
  logic Clock = 1'b0;
  logic Clear, start, mem_ready;
  logic [31:0] bus, ir;
  logic PCout, MARin, IncPC, Zin, Read, MDRin, PCin, MDRout, IRin;
  logic Gra, Rout, CONin, Yin, Cout, ZLOout, con, busy, done, illegal;
  int passed = 0;
  int total = 0;
  int step;
  int t1cnt;
  logic mcon, mill;
  logic [18:0] dv;
  localparam logic [14:0] ROM [7] = '{
    15'b111100000000000,
    15'b000011100000000,
    15'b000000011000000,
    15'b000000000111000,
    15'b100000000000100,
    15'b000100000000010,
    15'b000000000000001
  };
  branch_step_ctrl dut (
    .Clock(Clock), .Clear(Clear), .start(start), .mem_ready(mem_ready), .bus(bus), .ir(ir),
    .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .Zin(Zin), .Read(Read), .MDRin(MDRin),
    .PCin(PCin), .MDRout(MDRout), .IRin(IRin), .Gra(Gra), .Rout(Rout), .CONin(CONin),
    .Yin(Yin), .Cout(Cout), .ZLOout(ZLOout), .con(con), .busy(busy), .done(done), .illegal(illegal)
  );
  assign dv = {PCout, MARin, IncPC, Zin, Read, MDRin, PCin, MDRout, IRin,
               Gra, Rout, CONin, Yin, Cout, ZLOout, con, busy, done, illegal};
  always #5 Clock = ~Clock;
  function automatic logic [31:0] mk_ir(input logic [4:0] opc, input logic [1:0] c2);
    logic [31:0] r;
    r = 32'h0;
    r[31:27] = opc;
    r[20:19] = c2;
    return r;
  endfunction
  function automatic logic branch_taken(input logic [1:0] c2, input logic [31:0] b);
    if (c2 == 2'd0) return b == 0;
    if (c2 == 2'd1) return b != 0;
    if (c2 == 2'd2) return !b[31];
    return b[31];
  endfunction
  function automatic logic [18:0] expected();
    logic [14:0] s;
    s = (step < 0) ? 15'h0 : ROM[step];
    if (step == 6 && mcon) s[8] = 1'b1;
`ifdef MEM_WAIT_EN
    if (step == 1 && t1cnt != 0) s[8] = 1'b0;
`endif
    return {s, mcon, step >= 0, step == 6, mill};
  endfunction
  task automatic check(input string name, input logic [18:0] act, input logic [18:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %b, expected %b", name, act, req);
  endtask
  task automatic nxt();
    @(negedge Clock);
    #1;
  endtask
  // behavioural model: step number within the instruction, -1 meaning idle
  always @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      step <= -1;
      mcon <= 1'b0;
      mill <= 1'b0;
      t1cnt <= 0;
    end else begin
      mill <= 1'b0;
      t1cnt <= (step == 1) ? t1cnt + 1 : 0;
      case (step)
        -1: step <= start ? 0 : -1;
`ifdef MEM_WAIT_EN
        1: step <= mem_ready ? 2 : 1;
`endif
        2: begin
          if (ir[31:27] == 5'b10010) step <= 3;
          else begin
            step <= -1;
            mill <= 1'b1;
          end
        end
        3: begin
          mcon <= branch_taken(ir[20:19], bus);
          step <= 4;
        end
        6: step <= start ? 0 : -1;
        default: step <= step + 1;
      endcase
    end
  end
  // every-cycle comparison against the model
  always @(negedge Clock) if (!Clear) check("cycle", dv, expected());
  task automatic run_branch(input logic [31:0] irv, input logic [31:0] bv, input logic ec);
    ir = irv;
    bus = bv;
    start = 1'b1;
    nxt();
    check("t0_pcout", {18'b0, PCout}, 19'd1);
    start = 1'b0;
    repeat (4) nxt();
    check("t4_con", {18'b0, con}, {18'b0, ec});
    repeat (2) nxt();
    check("t6_zlo_pcin_done", {16'b0, ZLOout, PCin, done}, {16'b0, 1'b1, ec, 1'b1});
    nxt();
    check("after_busy", {18'b0, busy}, 19'd0);
  endtask
  logic [1:0]  tc2 [6] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2};
  logic [31:0] tbus [6] = '{32'h0, 32'h7, 32'h5, 32'h0, 32'h7FFF_FFFF, 32'h8000_0000};
  logic        tcon [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  initial begin
    Clear = 1'b1;
    start = 1'b0;
    mem_ready = 1'b1;
    bus = 32'h0;
    ir = 32'h0;
    #1;
    check("reset", dv, 19'h0);
    nxt();
    nxt();
    Clear = 1'b0;
    nxt();
    run_branch(mk_ir(5'b10010, 2'd3), 32'hFFFF_FFF0, 1'b1);
    run_branch(mk_ir(5'b10010, 2'd3), 32'd12, 1'b0);
    for (int i = 0; i < 6; i++) run_branch(mk_ir(5'b10010, tc2[i]), tbus[i], tcon[i]);
    ir = mk_ir(5'b00011, 2'd0);
    start = 1'b1;
    nxt();
    start = 1'b0;
    repeat (3) nxt();
    check("illegal_pulse", {17'b0, illegal, busy}, 19'b10);
    nxt();
    check("illegal_gone", {18'b0, illegal}, 19'd0);
    ir = mk_ir(5'b10010, 2'd0);
    bus = 32'h0;
    start = 1'b1;
    repeat (7) nxt();
    check("chain_t6", {17'b0, done, busy}, 19'b11);
    nxt();
    check("chain_t0", {16'b0, PCout, MARin, busy}, 19'b111);
    start = 1'b0;
    repeat (7) nxt();
    check("chain_end", {18'b0, busy}, 19'd0);
    ir = mk_ir(5'b10010, 2'd3);
    bus = 32'hFFFF_FFF0;
    start = 1'b1;
    nxt();
    start = 1'b0;
    repeat (4) nxt();
    check("pre_clear_t4", {17'b0, Yin, con}, 19'b11);
    #2 Clear = 1'b1;
    #1;
    check("clear_async", dv, 19'h0);
    nxt();
    Clear = 1'b0;
    start = 1'b1;
    nxt();
    check("restart_t0", {17'b0, PCout, MARin}, 19'b11);
    start = 1'b0;
    repeat (8) nxt();
    mem_ready = 1'b0;
    start = 1'b1;
    nxt();
    start = 1'b0;
    nxt();
    check("t1_first", {17'b0, Read, PCin}, 19'b11);
`ifdef MEM_WAIT_EN
    nxt();
    check("t1_wait_b", {17'b0, Read, PCin}, 19'b10);
    nxt();
    nxt();
    check("t1_wait_d", {17'b0, Read, PCin}, 19'b10);
    mem_ready = 1'b1;
`endif
    nxt();
    check("t2_after_t1", {18'b0, IRin}, 19'd1);
    mem_ready = 1'b1;
    repeat (6) nxt();
    check("final_idle", {18'b0, busy}, 19'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
